// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the pipelined MIPS core.
//
// Word stores complete in one cycle with no stall. Loads wait READ_LAT cycles
// with stall raised, then show the data for one cycle with stall low. When
// READ_LAT is 0 the load data comes straight from the array in the same cycle.
// A misaligned or out-of-range access sets the sticky err flag. An illegal
// store is dropped, and an illegal load returns 0.
//
// Optional feature: define DMEM_HALT_MONITOR_EN to build the halt monitor.
// The first store to HALT_ADDR sets done, and also sets pass when the stored
// value equals HALT_VALUE. Without the macro, done and pass are tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   addr       byte address from the MEM stage
//   wdata      store data
//   mem_write  store strobe
//   mem_read   load strobe, held until stall is low
//   rdata      load data, 0 unless a load is completing
//   stall      pipeline freeze request
//   err        sticky access-error flag
//   done/pass  halt monitor outputs
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          READ_LAT    = 2,
    parameter logic [31:0] HALT_ADDR   = 32'd80,
    parameter logic [31:0] HALT_VALUE  = 32'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        done,
    output logic        pass
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [AW-1:0]   ridx_q, ridx_d;
    logic            rok_q, rok_d;
    logic            err_q, err_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            legal;
    logic [AW-1:0]   widx;
    logic            idle, st_req, ld_req;

    assign legal  = (addr[1:0] == 2'b00) && ({1'b0, addr} < 33'(4 * DEPTH_WORDS));
    assign widx   = addr[AW+1:2];
    assign idle   = (state_q == IDLE);
    assign st_req = idle && mem_write;
    // A simultaneous store wins: the load is not started.
    assign ld_req = idle && mem_read && !mem_write && (READ_LAT > 0);

    // The array has no reset, so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (st_req && legal) mem_q[widx] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ridx_q  <= '0;
            rok_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ridx_q  <= ridx_d;
            rok_q   <= rok_d;
            err_q   <= err_d;
        end
    end

    // Next state. The request cycle counts as the first wait state, so data
    // is captured on the edge where the counter reaches zero. RESP then falls
    // in cycle READ_LAT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ridx_d  = ridx_q;
        rok_d   = rok_q;
        err_d   = err_q;
        if (idle && ((mem_read || mem_write) && !legal || (mem_read && mem_write)))
            err_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (ld_req) begin
                    ridx_d = widx;
                    rok_d  = legal;
                    if (READ_LAT == 1) begin
                        rdata_d = legal ? mem_q[widx] : '0;
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(READ_LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    rdata_d = rok_q ? mem_q[ridx_q] : '0;
                    state_d = RESP;
                end
            end
            // The held mem_read is ignored here, so it cannot start a second load.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. These are gated by reset so they drop immediately while reset is low.
    always_comb begin
        stall = reset && (ld_req || (state_q == WAIT));
        rdata = '0;
        if (READ_LAT == 0) begin
            if (reset && mem_read && !mem_write && legal) rdata = mem_q[widx];
        end else if (state_q == RESP) begin
            rdata = rdata_q;
        end
    end

    assign err = err_q;

`ifdef DMEM_HALT_MONITOR_EN
    logic done_q, pass_q;

    // Only the first halt store is recorded. It is recorded even when the
    // address is illegal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (st_req && (addr == HALT_ADDR) && !done_q) begin
            done_q <= 1'b1;
            pass_q <= (wdata == HALT_VALUE);
        end
    end

    assign done = done_q;
    assign pass = pass_q;
`else
    assign done = 1'b0;
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        mem_write, mem_read, stall, err, done, pass;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_write, z_read, z_stall, z_err, z_done, z_pass;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .READ_LAT(2), .HALT_ADDR(32'd80), .HALT_VALUE(32'd7)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
        .mem_read(mem_read), .rdata(rdata), .stall(stall), .err(err), .done(done), .pass(pass));

    dmem_responder #(.DEPTH_WORDS(64), .READ_LAT(0), .HALT_ADDR(32'd80), .HALT_VALUE(32'd7)) u_dut0 (
        .clk(clk), .reset(reset), .addr(z_addr), .wdata(z_wdata), .mem_write(z_write),
        .mem_read(z_read), .rdata(z_rdata), .stall(z_stall), .err(z_err), .done(z_done), .pass(z_pass));

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        bit          exp_err;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    vec_t        va[8];
    vec_t        vc[4];

`ifdef DMEM_HALT_MONITOR_EN
    localparam bit HM = 1'b1;
`else
    localparam bit HM = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b0; addr = a; wdata = d;
        #1 chk("store_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp);
        int          ns;
        bit          got;
        logic [31:0] e;
        ns  = 0;
        got = 1'b0;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; addr = a;
        sb_q.push_back(exp);
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (stall) begin
                chk("rdata_while_stalled", rdata, 32'd0);
                ns++;
                @(negedge clk);
            end else begin
                got = 1'b1;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL load_timeout: stall still high after 20 cycles, required low");
        end else begin
            chk("load_rdata", rdata, e);
            chk("load_stall_cycles", 32'(ns), 32'd2);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b0;
        #1 chk("no_retrigger_stall", 32'(stall), 32'd0);
        chk("idle_rdata", rdata, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b0;
        reset = 1'b0;
        #1 chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done_pass", {30'd0, done, pass}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wr) do_store(v.a, v.d);
        else      do_load(v.a, v.exp);
        chk("err_flag", 32'(err), 32'(v.exp_err));
    endtask

    initial begin
        va[0] = '{1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0};
        va[1] = '{1'b1, 32'h3C, 32'h0000_00A5, 32'h0, 1'b0};
        va[2] = '{1'b1, 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b0};
        va[3] = '{1'b1, 32'hFC, 32'hCAFE_F00D, 32'h0, 1'b0};
        va[4] = '{1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0};
        va[5] = '{1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0};
        va[6] = '{1'b0, 32'hFC, 32'h0, 32'hCAFE_F00D, 1'b0};
        va[7] = '{1'b0, 32'h3C, 32'h0, 32'h0000_00A5, 1'b0};
        // Illegal accesses: the misaligned store must not touch word 4, and
        // 0x400 aliases word 0 but must still return 0.
        vc[0] = '{1'b1, 32'h11,  32'hFFFF_FFFF, 32'h0, 1'b1};
        vc[1] = '{1'b0, 32'h10,  32'h0, 32'h1234_5678, 1'b1};
        vc[2] = '{1'b0, 32'h400, 32'h0, 32'h0, 1'b1};
        vc[3] = '{1'b0, 32'h13,  32'h0, 32'h0, 1'b1};

        reset = 1'b1;
        addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0;
        z_addr = '0; z_wdata = '0; z_write = 1'b0; z_read = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_done_pass", {30'd0, done, pass}, 32'd0);
        chk("reset_lat0_outs", {z_rdata[29:0], z_stall, z_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // READ_LAT=0 instance: the load data appears combinationally.
        @(negedge clk);
        z_write = 1'b1; z_addr = 32'h3C; z_wdata = 32'hA5;
        #1 chk("lat0_store_stall", 32'(z_stall), 32'd0);
        @(negedge clk);
        z_write = 1'b0; z_read = 1'b1;
        #1 chk("lat0_rdata", z_rdata, 32'hA5);
        chk("lat0_stall", 32'(z_stall), 32'd0);
        @(negedge clk);
        z_read = 1'b0;
        #1 chk("lat0_rdata_idle", z_rdata, 32'd0);
        chk("lat0_err_clean", 32'(z_err), 32'd0);
        @(negedge clk);
        z_read = 1'b1; z_addr = 32'h400;
        #1 chk("lat0_illegal_rdata", z_rdata, 32'd0);
        chk("lat0_illegal_stall", 32'(z_stall), 32'd0);
        @(posedge clk);
        #1 chk("lat0_err", 32'(z_err), 32'd1);
        @(negedge clk);
        z_read = 1'b0;

        // Legal stores and loads from the table.
        foreach (va[i]) run_vec(va[i]);
        go_idle();

        // A load in the cycle right after a store to the same word.
        do_store(32'h24, 32'h0BAD_CAFE);
        do_load(32'h24, 32'h0BAD_CAFE);
        go_idle();

        // Both strobes at once: the store is performed, no load runs, err is set.
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b1; addr = 32'h20; wdata = 32'd5;
        #1 chk("both_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 chk("both_err", 32'(err), 32'd1);
        go_idle();
        do_load(32'h20, 32'd5);
        go_idle();

        pulse_reset();
        foreach (vc[i]) run_vec(vc[i]);
        go_idle();

        // Reset arrives while a load is in WAIT.
        pulse_reset();
        do_store(32'h44, 32'h0000_1111);
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; addr = 32'h44;
        @(negedge clk);
        #1 chk("wait_stall_before_rst", 32'(stall), 32'd1);
        reset = 1'b0;
        #1 chk("midload_rst_stall", 32'(stall), 32'd0);
        chk("midload_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        mem_read = 1'b0;
        reset = 1'b1;
        go_idle();
        do_load(32'h44, 32'h0000_1111);
        go_idle();

        // Halt monitor.
        do_store(32'd80, 32'd7);
        chk("halt7_done_pass", {30'd0, done, pass}, HM ? 32'd3 : 32'd0);
        pulse_reset();
        do_store(32'd80, 32'd9);
        chk("halt9_done_pass", {30'd0, done, pass}, HM ? 32'd2 : 32'd0);
        do_store(32'd80, 32'd7);
        chk("halt_sticky", {30'd0, done, pass}, HM ? 32'd2 : 32'd0);
        do_load(32'd80, 32'd7);
        go_idle();

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
